// File: rtl/vme_fifo_initiator.sv
// rtl/vme_fifo_initiator.sv - DMB FIFO command-port bus initiator (single STROBE/DTACK_B cycles)
// Optional: VME_INIT_TIMEOUT_EN enables the DTACK timeout counter and ABORT path.
module vme_fifo_initiator #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        FASTCLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_WRITE,
    input  logic [9:0]  REQ_CMD,
    input  logic [15:0] REQ_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RD_DATA,
    output logic        DEVICE,
    output logic [9:0]  COMMAND,
    output logic        WRITE_B,
    output logic        STROBE,
    output logic        STRBCE,
    output logic [15:0] BUS_DOUT,
    input  logic [15:0] BUS_DIN,
    input  logic        DTACK_B
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STRB, S_CAPT, S_RELS, S_ABORT, S_FIN
    } state_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);

    state_t      state_q;
    logic [1:0]  dtk_q;
    logic        dtk_s;
    logic        seen_hi_q;
    logic [7:0]  cnt_q;
    logic        busy_q, done_q, device_q, write_b_q, strobe_q, strbce_q;
    logic [9:0]  command_q;
    logic [15:0] dout_q, rd_data_q;

    always_ff @(posedge FASTCLK) begin
        if (RST) dtk_q <= 2'b11;
        else     dtk_q <= {dtk_q[0], DTACK_B};
    end
    assign dtk_s = dtk_q[1];

`ifdef VME_INIT_TIMEOUT_EN
    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYC);
    logic [7:0] tmo_q;
    logic       err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            seen_hi_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            device_q  <= 1'b0;
            write_b_q <= 1'b1;
            strobe_q  <= 1'b0;
            strbce_q  <= 1'b0;
            command_q <= '0;
            dout_q    <= '0;
            rd_data_q <= '0;
`ifdef VME_INIT_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (REQ && !busy_q) begin
                        busy_q    <= 1'b1;
                        device_q  <= 1'b1;
                        command_q <= REQ_CMD;
                        write_b_q <= ~REQ_WRITE;
                        dout_q    <= REQ_DATA;
                        cnt_q     <= SETUP_LOAD;
`ifdef VME_INIT_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        strobe_q  <= 1'b1;
                        strbce_q  <= 1'b1;
                        seen_hi_q <= 1'b0;
`ifdef VME_INIT_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                        state_q   <= S_STRB;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_STRB: begin
                    strbce_q <= 1'b0;
                    if (dtk_s) seen_hi_q <= 1'b1;
                    // An ack left over from a previous cycle is ignored until DTACK_B was seen high.
                    if (!dtk_s && seen_hi_q) begin
                        state_q <= S_CAPT;
                    end
`ifdef VME_INIT_TIMEOUT_EN
                    else if (tmo_q == TMO_MAX) begin
                        state_q <= S_ABORT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                S_CAPT: begin
                    if (write_b_q) rd_data_q <= BUS_DIN;
                    strobe_q <= 1'b0;
`ifdef VME_INIT_TIMEOUT_EN
                    tmo_q    <= '0;
`endif
                    state_q  <= S_RELS;
                end
                S_RELS: begin
                    if (dtk_s) begin
                        done_q    <= 1'b1;
                        device_q  <= 1'b0;
                        write_b_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
`ifdef VME_INIT_TIMEOUT_EN
                    else if (tmo_q == TMO_MAX) begin
                        state_q <= S_ABORT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                S_ABORT: begin
                    strobe_q  <= 1'b0;
                    strbce_q  <= 1'b0;
                    done_q    <= 1'b1;
                    device_q  <= 1'b0;
                    write_b_q <= 1'b1;
`ifdef VME_INIT_TIMEOUT_EN
                    err_q     <= 1'b1;
`endif
                    state_q   <= S_FIN;
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RD_DATA  = rd_data_q;
    assign DEVICE   = device_q;
    assign COMMAND  = command_q;
    assign WRITE_B  = write_b_q;
    assign STROBE   = strobe_q;
    assign STRBCE   = strbce_q;
    assign BUS_DOUT = dout_q;

endmodule

// File: tb/tb_vme_fifo_initiator.sv
// tb/tb_vme_fifo_initiator.sv - directed self-checking bench for vme_fifo_initiator
module tb_vme_fifo_initiator;

    logic        FASTCLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic        REQ_WRITE = 1'b0;
    logic [9:0]  REQ_CMD = '0;
    logic [15:0] REQ_DATA = '0;
    logic        BUSY, DONE, ERR, DEVICE, WRITE_B, STROBE, STRBCE;
    logic [15:0] RD_DATA, BUS_DOUT;
    logic [9:0]  COMMAND;
    logic [15:0] BUS_DIN = 16'hFFFF;
    logic        DTACK_B = 1'b1;

    int tests = 0;
    int fails = 0;

    int r_done, r_lat, r_err, r_strbce, r_strb_at, r_bus_bad, r_busy_after, r_strobe_at_done;

    vme_fifo_initiator #(.SETUP_CYC(2), .TIMEOUT_CYC(16)) dut (
        .FASTCLK(FASTCLK), .RST(RST), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_CMD(REQ_CMD), .REQ_DATA(REQ_DATA), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .RD_DATA(RD_DATA), .DEVICE(DEVICE), .COMMAND(COMMAND),
        .WRITE_B(WRITE_B), .STROBE(STROBE), .STRBCE(STRBCE),
        .BUS_DOUT(BUS_DOUT), .BUS_DIN(BUS_DIN), .DTACK_B(DTACK_B)
    );

    always #5 FASTCLK = ~FASTCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host request with a cycle-by-cycle responder; n counts negedges after the accepting edge.
    task automatic run_cycle(input logic wr, input logic [9:0] cmd, input logic [15:0] data,
                             input logic [15:0] din, input bit ack_en, input int rel_extra,
                             input bit busy_req);
        int rel_cnt;
        int post;
        bit prev_strobe;
        r_done = 0; r_lat = -1; r_err = -1; r_strbce = 0; r_strb_at = -1;
        r_bus_bad = 0; r_busy_after = -1; r_strobe_at_done = -1;
        rel_cnt = 0; post = -1; prev_strobe = 0;
        @(negedge FASTCLK);
        REQ = 1'b1; REQ_WRITE = wr; REQ_CMD = cmd; REQ_DATA = data;
        for (int n = 1; n <= 80; n++) begin
            @(negedge FASTCLK);
            if (n == 1) REQ = 1'b0;
            if (busy_req && n == 5) begin
                REQ = 1'b1; REQ_WRITE = 1'b1; REQ_CMD = 10'd3; REQ_DATA = 16'hBEEF;
            end
            if (busy_req && n == 6) REQ = 1'b0;
            if (STRBCE) r_strbce++;
            if (STROBE && r_strb_at < 0) r_strb_at = n;
            if (STROBE && (DEVICE !== 1'b1 || COMMAND !== cmd || WRITE_B !== ~wr ||
                           (wr && BUS_DOUT !== data))) r_bus_bad++;
            if (DONE) begin
                r_done++;
                if (r_lat < 0) begin
                    r_lat = n; r_err = ERR; r_strobe_at_done = STROBE; post = 0;
                end
            end
            if (post == 1) r_busy_after = BUSY;
            if (ack_en) begin
                if (STROBE && prev_strobe) begin
                    DTACK_B = 1'b0; BUS_DIN = din;
                end else if (!STROBE && DTACK_B == 1'b0) begin
                    if (rel_cnt == rel_extra) DTACK_B = 1'b1;
                    else rel_cnt++;
                end
            end
            prev_strobe = STROBE;
            if (post >= 0) begin
                if (post == 3) break;
                post++;
            end
        end
        DTACK_B = 1'b1;
        REQ = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge FASTCLK);
        chk("rst_busy", BUSY, 0);     chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);       chk("rst_device", DEVICE, 0);
        chk("rst_strobe", STROBE, 0); chk("rst_strbce", STRBCE, 0);
        chk("rst_write_b", WRITE_B, 1); chk("rst_command", COMMAND, 0);
        chk("rst_bus_dout", BUS_DOUT, 0); chk("rst_rd_data", RD_DATA, 0);
        RST = 1'b0;

        // Write select, ack 1 cycle after STROBE
        run_cycle(1'b1, 10'd8, 16'h0055, 16'hC0DE, 1'b1, 0, 1'b0);
        chk("t1_done_cnt", r_done, 1);   chk("t1_lat", r_lat, 11);
        chk("t1_err", r_err, 0);         chk("t1_strbce", r_strbce, 1);
        chk("t1_strb_at", r_strb_at, 3); chk("t1_bus", r_bus_bad, 0);
        chk("t1_busy_after", r_busy_after, 0); chk("t1_rd_data", RD_DATA, 16'h0000);
        chk("t1_write_b_idle", WRITE_B, 1); chk("t1_device_idle", DEVICE, 0);

        // Read select
        run_cycle(1'b0, 10'd9, 16'h0000, 16'h2A55, 1'b1, 0, 1'b0);
        chk("t2_done_cnt", r_done, 1);   chk("t2_lat", r_lat, 11);
        chk("t2_bus", r_bus_bad, 0);     chk("t2_rd_data", RD_DATA, 16'h2A55);

        // Responder holds DTACK_B 3 cycles past STROBE fall
        run_cycle(1'b0, 10'd5, 16'h0000, 16'h1234, 1'b1, 3, 1'b0);
        chk("t3_done_cnt", r_done, 1);   chk("t3_lat", r_lat, 14);
        chk("t3_rd_data", RD_DATA, 16'h1234);

        // REQ while BUSY is ignored, then a normal request
        run_cycle(1'b1, 10'd2, 16'hA5A5, 16'h9999, 1'b1, 0, 1'b1);
        chk("t5_done_cnt", r_done, 1);   chk("t5_lat", r_lat, 11);
        chk("t5_bus", r_bus_bad, 0);     chk("t5_rd_data", RD_DATA, 16'h1234);
        chk("t5_busy_idle", BUSY, 0);
        run_cycle(1'b1, 10'd11, 16'h0001, 16'h9999, 1'b1, 0, 1'b0);
        chk("t5b_done_cnt", r_done, 1);  chk("t5b_lat", r_lat, 11);
        chk("t5b_bus", r_bus_bad, 0);

`ifdef VME_INIT_TIMEOUT_EN
        // No DTACK: abort after TIMEOUT_CYC
        run_cycle(1'b0, 10'd4, 16'h0000, 16'h7777, 1'b0, 0, 1'b0);
        chk("t4_done_cnt", r_done, 1);   chk("t4_lat", r_lat, 21);
        chk("t4_err", r_err, 1);         chk("t4_strobe_at_done", r_strobe_at_done, 0);
        chk("t4_bus", r_bus_bad, 0);     chk("t4_rd_data", RD_DATA, 16'h1234);
        run_cycle(1'b0, 10'd6, 16'h0000, 16'h0F0F, 1'b1, 0, 1'b0);
        chk("t4b_err_clear", r_err, 0);  chk("t4b_rd_data", RD_DATA, 16'h0F0F);
`else
        // No DTACK and no timeout: the cycle hangs until reset
        @(negedge FASTCLK);
        REQ = 1'b1; REQ_WRITE = 1'b0; REQ_CMD = 10'd4;
        @(negedge FASTCLK);
        REQ = 1'b0;
        r_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge FASTCLK);
            if (DONE) r_done++;
        end
        chk("t4n_no_done", r_done, 0);   chk("t4n_strobe", STROBE, 1);
        chk("t4n_busy", BUSY, 1);        chk("t4n_err", ERR, 0);
        RST = 1'b1;
        @(negedge FASTCLK);
        RST = 1'b0;
        chk("t4n_rst_strobe", STROBE, 0); chk("t4n_rst_rd", RD_DATA, 16'h0000);
`endif

        // Reset during STRB
        @(negedge FASTCLK);
        REQ = 1'b1; REQ_WRITE = 1'b1; REQ_CMD = 10'd7; REQ_DATA = 16'h3C3C;
        @(negedge FASTCLK);
        REQ = 1'b0;
        r_strb_at = -1;
        for (int n = 0; n < 20; n++) begin
            if (STROBE) begin r_strb_at = n; break; end
            @(negedge FASTCLK);
        end
        chk("t6_strobe_seen", (r_strb_at >= 0), 1);
        RST = 1'b1;
        @(negedge FASTCLK);
        RST = 1'b0;
        chk("t6_strobe", STROBE, 0);     chk("t6_device", DEVICE, 0);
        chk("t6_write_b", WRITE_B, 1);   chk("t6_busy", BUSY, 0);
        chk("t6_done", DONE, 0);
        r_done = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge FASTCLK);
            if (DONE) r_done++;
        end
        chk("t6_no_done", r_done, 0);
        run_cycle(1'b0, 10'd9, 16'h0000, 16'h5A5A, 1'b1, 0, 1'b0);
        chk("t6b_done_cnt", r_done, 1);  chk("t6b_lat", r_lat, 11);
        chk("t6b_rd_data", RD_DATA, 16'h5A5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
